// File: rtl/arc4_pkg.sv
// Shared definitions for the plaintext reader: FSM state encoding, fixed
// memory addresses and the printable-character window.
package arc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_LEN   = 3'd1,
        ST_WAIT_LEN = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } pt_state_e;

    localparam logic [7:0] PT_LEN_ADDR = 8'h00;
    localparam logic [7:0] PRINT_LO    = 8'h20;
    localparam logic [7:0] PRINT_HI    = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/pt_reader_if.sv
// Bundle of the reader's control, memory-read and output-stream signals.
// np_err exists only when PT_READER_PRINTABLE_CHECK_EN is defined.
interface pt_reader_if;

    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef PT_READER_PRINTABLE_CHECK_EN
    logic       np_err;

    modport slave (
        input  en, pt_rddata, out_ready,
        output rdy, pt_addr, out_data, out_valid, out_last, np_err
    );

    modport master (
        output en, pt_rddata, out_ready,
        input  rdy, pt_addr, out_data, out_valid, out_last, np_err
    );
`else
    modport slave (
        input  en, pt_rddata, out_ready,
        output rdy, pt_addr, out_data, out_valid, out_last
    );

    modport master (
        output en, pt_rddata, out_ready,
        input  rdy, pt_addr, out_data, out_valid, out_last
    );
`endif

endinterface

// File: rtl/pt_skid_fifo.sv
// Small output buffer with valid/ready on both sides. When empty the input
// falls straight through, so a byte reaches the sink in the cycle it arrives.
module pt_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [W-1:0]             in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [W-1:0]             out_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty      = (count_q == '0);
    assign in_ready_o = (count_q != FULL_CNT);

    // A byte is stored unless it passes straight through an empty buffer.
    assign push = in_valid_i && in_ready_o && !(empty && out_ready_i);
    assign pop  = !empty && out_ready_i;

    assign out_valid_o = !empty || in_valid_i;
    assign out_data_o  = !empty    ? mem_q[rd_ptr_q] :
                         in_valid_i ? in_data_i       : '0;
    assign count_o     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/pt_reader.sv
// Streams a length-prefixed message out of a registered-read memory.
// Optional feature macro: PT_READER_PRINTABLE_CHECK_EN (sticky np_err flag).
module pt_reader
    import arc4_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    pt_reader_if.slave  bus
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    pt_state_e   state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  addr_cnt_q, addr_cnt_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic        inflight_q;
    logic        inflight_last_q;

    logic        accept;
    logic        issue;
    logic        issue_last;
    logic        beat;
    logic        credit_ok;
    logic [CW:0] used;

    logic [CW-1:0] fifo_count;
    logic          fifo_in_ready;
    logic          fifo_out_valid;
    logic [8:0]    fifo_out_data;

    assign accept = (state_q == ST_IDLE) && bus.en;
    assign beat   = fifo_out_valid && bus.out_ready;

    // Buffered bytes plus the one read that may still be in flight must
    // always fit, so a returning byte can never be refused.
    assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign credit_ok = (used < DEPTH_W) && fifo_in_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_cnt_d = addr_cnt_q;
        pt_addr_d  = pt_addr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RD_LEN;
                end
            end
            ST_RD_LEN: begin
                pt_addr_d = PT_LEN_ADDR;
                state_d   = ST_WAIT_LEN;
            end
            ST_WAIT_LEN: begin
                len_d      = bus.pt_rddata;
                addr_cnt_d = 8'd1;
                state_d    = (bus.pt_rddata == 8'd0) ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                if (credit_ok) begin
                    issue     = 1'b1;
                    pt_addr_d = addr_cnt_q;
                    // Stop at L instead of incrementing, so L=255 never wraps.
                    if (addr_cnt_q == len_q) begin
                        issue_last = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && fifo_out_data[8]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            len_q           <= '0;
            addr_cnt_q      <= '0;
            pt_addr_q       <= PT_LEN_ADDR;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            addr_cnt_q      <= addr_cnt_d;
            pt_addr_q       <= pt_addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
        end
    end

    // The address is presented in the cycle the read is issued and held after.
    assign bus.pt_addr = pt_addr_d;
    assign bus.rdy     = (state_q == ST_IDLE);

    pt_skid_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (9)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({inflight_last_q, bus.pt_rddata}),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (fifo_out_data),
        .count_o     (fifo_count)
    );

    assign bus.out_valid = fifo_out_valid;
    assign bus.out_data  = fifo_out_data[7:0];
    assign bus.out_last  = fifo_out_data[8];

`ifdef PT_READER_PRINTABLE_CHECK_EN
    logic np_err_q, np_err_d;

    always_comb begin
        np_err_d = np_err_q;
        if (accept) begin
            np_err_d = 1'b0;
        end else if (beat && !is_printable(fifo_out_data[7:0])) begin
            np_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            np_err_q <= 1'b0;
        end else begin
            np_err_q <= np_err_d;
        end
    end

    assign bus.np_err = np_err_q;
`endif

endmodule

// File: tb/tb_pt_reader.sv
// Scoreboard bench for pt_reader: expected bytes are queued when a message is
// started and compared as beats leave the DUT.
module tb_pt_reader;

    localparam int RM_LOW  = 0;
    localparam int RM_HIGH = 1;
    localparam int RM_TOG  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pt_reader_if bus();

    pt_reader #(.BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    always @(posedge clk) bus.pt_rddata <= mem[bus.pt_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = RM_HIGH;
    int accept_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc, msg_beats;
    bit seen_valid, stall_pending, rdy_pending;
    logic [7:0] held_data, max_addr;
    logic       held_last;
    logic [8:0] exp_q [$];
    logic [8:0] exp_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                RM_HIGH: bus.out_ready = 1'b1;
                RM_TOG:  bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rdy_pending) check("rdy_after_last", bus.rdy, 1);
        rdy_pending = 1'b0;
        if (stall_pending) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, held_data);
            check("stall_last", bus.out_last, held_last);
        end
        if (bus.out_valid === 1'b1 && !seen_valid) begin
            seen_valid      = 1'b1;
            first_valid_cyc = cyc;
        end
        if (bus.pt_addr > max_addr) max_addr = bus.pt_addr;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_size_at_beat", exp_q.size(), 1);
            end else begin
                exp_e = exp_q.pop_front();
                check("beat_data", bus.out_data, exp_e[7:0]);
                check("beat_last", bus.out_last, exp_e[8]);
            end
            if (msg_beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            msg_beats++;
            if (bus.out_last) rdy_pending = 1'b1;
        end
        stall_pending = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0) && !rst;
        held_data = bus.out_data;
        held_last = bus.out_last;
    end

    task automatic load_msg(input int len, input int base, input int step);
        mem[0] = 8'(len);
        for (int i = 1; i <= len; i++) mem[i] = 8'(base + i * step);
    endtask

    task automatic start_msg(input int len, input int mode);
        logic lb;
        for (int i = 1; i <= len; i++) begin
            lb = (i == len);
            exp_q.push_back({lb, mem[i]});
        end
        ready_mode = mode;
        @(posedge clk);
        #1;
        check("rdy_idle", bus.rdy, 1);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en     = 1'b0;
        accept_cyc = cyc;
        msg_beats  = 0;
        seen_valid = 1'b0;
        max_addr   = 8'h00;
        check("rdy_low_after_en", bus.rdy, 0);
    endtask

    task automatic wait_done(input int len, input int mode, input int budget);
        int g;
        int lat;
        g = 0;
        while ((exp_q.size() != 0 || bus.rdy !== 1'b1) && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("msg_done_in_budget", (g < budget), 1);
        check("beat_count", msg_beats, len);
        lat = first_valid_cyc - accept_cyc + 1;
        if (len == 0) begin
            check("len0_rdy_within3", (g <= 3), 1);
        end else begin
            check("first_valid_le4", (lat <= 4), 1);
            check("max_pt_addr", max_addr, len);
            if (mode == RM_HIGH) check("sustained_rate", last_beat_cyc - first_beat_cyc, len - 1);
        end
        $display("MSG L=%0d mode=%0d beats=%0d cycles=%0d first_valid_lat=%0d", len, mode, msg_beats, g, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rdy", bus.rdy, 1);
        check("rst_pt_addr", bus.pt_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
`ifdef PT_READER_PRINTABLE_CHECK_EN
        check("rst_np_err", bus.np_err, 0);
`endif

        // "ABC" with the sink always ready
        mem[0] = 8'h03; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h43;
        start_msg(3, RM_HIGH);
        wait_done(3, RM_HIGH, 50);
`ifdef PT_READER_PRINTABLE_CHECK_EN
        check("abc_np_err", bus.np_err, 0);
`endif

        // Empty message
        mem[0] = 8'h00;
        start_msg(0, RM_HIGH);
        wait_done(0, RM_HIGH, 20);

        // Longest message with a sink that stalls every other cycle
        load_msg(255, 7, 3);
        start_msg(255, RM_TOG);
        wait_done(255, RM_TOG, 2000);
        check("last_pt_addr", bus.pt_addr, 8'hFF);

        // Reset after five beats, then the full message again
        load_msg(20, 8'h60, 1);
        start_msg(20, RM_HIGH);
        g = 0;
        while (msg_beats < 5 && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        check("five_beats_seen", (msg_beats >= 5), 1);
        ready_mode = RM_LOW;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_rdy", bus.rdy, 1);
        check("mid_rst_pt_addr", bus.pt_addr, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_out_data", bus.out_data, 0);
`ifdef PT_READER_PRINTABLE_CHECK_EN
        check("mid_rst_np_err", bus.np_err, 0);
`endif
        @(negedge clk);
        check("stale_read_dropped", bus.out_valid, 0);
        start_msg(20, RM_HIGH);
        wait_done(20, RM_HIGH, 100);

        // en pulsed again while busy must not restart the transfer
        load_msg(10, 8'h30, 2);
        start_msg(10, RM_HIGH);
        repeat (5) @(posedge clk);
        #1;
        check("rdy_busy", bus.rdy, 0);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        wait_done(10, RM_HIGH, 100);
        repeat (5) @(posedge clk);
        #1;
        check("no_restart_beats", msg_beats, 10);

`ifdef PT_READER_PRINTABLE_CHECK_EN
        mem[0] = 8'h02; mem[1] = 8'h41; mem[2] = 8'h07;
        start_msg(2, RM_HIGH);
        wait_done(2, RM_HIGH, 50);
        check("np_err_set", bus.np_err, 1);
        repeat (4) @(posedge clk);
        #1;
        check("np_err_held", bus.np_err, 1);
        mem[0] = 8'h02; mem[1] = 8'h41; mem[2] = 8'h42;
        start_msg(2, RM_HIGH);
        check("np_err_clr_on_en", bus.np_err, 0);
        wait_done(2, RM_HIGH, 50);
        check("np_err_printable", bus.np_err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_reader.md
PT_READER -- requirements
Module: pt_reader

Interface
REQ-001 Parameter: BUF_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  start request; accepted only in the cycle rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 pt_addr  output  8  read address into plaintext memory.
REQ-007 pt_rddata  input  8  read data; valid exactly 1 cycle after pt_addr is presented (registered memory).
REQ-008 out_data  output  8  streamed plaintext byte.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  sink accepts; a beat transfers when out_valid & out_ready.
REQ-011 out_last  output  1  marks final byte of the message; qualified by out_valid.
REQ-012 np_err  output  1  sticky non-printable flag; present only with PT_READER_PRINTABLE_CHECK_EN.

Function
REQ-013 Memory holds a length-prefixed message: byte 0 = L (0..255), bytes 1..L = plaintext.
REQ-014 FSM states IDLE, RD_LEN, WAIT_LEN, STREAM, DRAIN; the block SHALL use no other states.
REQ-015 IDLE: rdy=1; en=1 -> RD_LEN, rdy=0 from the next cycle; en=0 -> stay.
REQ-016 RD_LEN: drive pt_addr=0 -> WAIT_LEN; WAIT_LEN: capture L from pt_rddata.
REQ-017 L=0: return to IDLE with no beats emitted; rdy=1 no later than 3 cycles after en acceptance.
REQ-018 L>0: STREAM issues reads at addresses 1..L in increasing order, one per cycle max.
REQ-019 A read SHALL be issued only when buffered entries plus in-flight reads < BUF_DEPTH; no byte is ever dropped or duplicated.
REQ-020 Bytes leave in address order; out_last=1 exactly on byte L.
REQ-021 With out_ready held high, first out_valid SHALL occur no later than 4 cycles after en acceptance, followed by one byte per cycle sustained.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-023 After all L reads are issued -> DRAIN; when the byte-L beat transfers -> IDLE, rdy=1 the following cycle.
REQ-024 Address counter is 8 bits; L=255 ends at pt_addr=255 with no wrap and no read beyond L.
REQ-025 en while rdy=0 SHALL be ignored and SHALL NOT restart or perturb the transfer.
REQ-026 pt_addr holds its last value when no read is issued; the block never writes memory.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, rdy=1, pt_addr=0, out_valid=0, out_last=0, out_data=0, buffer emptied, np_err=0.
REQ-028 rst mid-transfer aborts the message; in-flight read data returning after reset SHALL be discarded.
REQ-029 rst has priority over en in the same cycle.

Configuration
REQ-030 Macro PT_READER_PRINTABLE_CHECK_EN defined: np_err port exists; set when a transferred byte lies outside 8'h20..8'h7E; cleared only by rst or by en acceptance.
REQ-031 Macro undefined: np_err port and check logic absent; all other behaviour identical cycle for cycle.

Structure
REQ-032 Shared package arc4_pkg SHALL hold the FSM state enum, PT_LEN_ADDR=8'h00, PRINT_LO=8'h20, PRINT_HI=8'h7E.
REQ-033 One sub-module pt_skid_fifo (BUF_DEPTH entries, 9-bit data+last, valid/ready both sides) SHALL implement the output buffer.

Verification
REQ-034 Mem {8'h03,"A","B","C"}, en pulse, out_ready=1 -> beats 8'h41,8'h42,8'h43, out_last only on 8'h43, rdy=1 afterwards.
REQ-035 Mem byte0=8'h00, en -> zero beats, rdy=1 within 3 cycles.
REQ-036 L=8'hFF, out_ready toggled 1/0 each cycle -> 255 bytes in order, data stable while stalled, last pt_addr=8'hFF.
REQ-037 rst asserted for 1 cycle after 5 beats of an L=20 message -> all outputs at reset values, next en streams full message from byte 1.
REQ-038 en re-pulsed mid-transfer of L=10 -> exactly 10 beats, no restart.
REQ-039 With PT_READER_PRINTABLE_CHECK_EN, mem {8'h02,8'h41,8'h07} -> np_err=1 after second beat, held until next en.
